// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and op width.
package alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      OR  = 3'b011,
      XOR = 3'b100,
      SHL = 3'b101,
      SHR = 3'b110,
      MUL = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor: m=1 computes x + ~y + 1, with carry-out and signed overflow.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             m,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] y_eff;
   logic [WIDTH:0]   full;

   assign y_eff = y ^ {WIDTH{m}};
   assign full  = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, m};
   assign sum   = full[WIDTH-1:0];
   assign cout  = full[WIDTH];
   assign ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; shifts and multiply iterate one bit per cycle.
// Handshake: an op is taken on a rising edge with in_valid && in_ready; a result is released on a rising edge with out_valid && out_ready.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_ovf,
   output logic             flag_neg,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] W_B   = WIDTH'(WIDTH);
   localparam logic [CNT_W-1:0] W_C   = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   alu_state_t       state_q, state_d;
   alu_op_t          op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d, ovf_q, ovf_d, lost_q, lost_d;

   logic             idle, done;
   alu_op_t          op_s;
   logic [WIDTH-1:0] a_s, b_s, acc_s, sh_src, as_x, as_y, as_sum;
   logic             as_m, as_cout, as_ovf, carry_s, lost_s;
   logic [WIDTH-1:0] step_res, step_a, step_b, n_full;
   logic             step_c, step_lost;
   logic [CNT_W-1:0] n;

   // In IDLE the step operands come straight from the ports, so the accept
   // cycle already performs the first iteration of a shift or multiply.
   assign idle    = (state_q == IDLE);
   assign done    = (state_q == DONE);
   assign op_s    = idle ? alu_op_t'(op) : op_q;
   assign a_s     = idle ? a : a_q;
   assign b_s     = idle ? b : b_q;
   assign acc_s   = idle ? '0 : res_q;
   assign sh_src  = idle ? a : res_q;
   assign carry_s = idle ? 1'b0 : carry_q;
   assign lost_s  = idle ? 1'b0 : lost_q;
   assign n_full  = (b >= W_B) ? W_B : b;
   assign n       = CNT_W'(n_full);

   assign as_x = (op_s == MUL) ? acc_s : a_s;
   assign as_y = (op_s == MUL) ? a_s : b_s;
   assign as_m = (op_s == SUB);

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .x    (as_x),
      .y    (as_y),
      .m    (as_m),
      .sum  (as_sum),
      .cout (as_cout),
      .ovf  (as_ovf)
   );

   // lost tracks multiplicand bits shifted past the top; adding such a
   // truncated partial product means the true product exceeds WIDTH bits.
   always_comb begin
      step_res  = acc_s;
      step_c    = carry_s;
      step_a    = {a_s[WIDTH-2:0], 1'b0};
      step_b    = {1'b0, b_s[WIDTH-1:1]};
      step_lost = lost_s | a_s[WIDTH-1];
      case (op_s)
         SHL: begin
            step_res = {sh_src[WIDTH-2:0], 1'b0};
            step_c   = sh_src[WIDTH-1];
         end
         SHR: begin
            step_res = {1'b0, sh_src[WIDTH-1:1]};
            step_c   = sh_src[0];
         end
         MUL: begin
            if (b_s[0]) begin
               step_res = as_sum;
               step_c   = carry_s | as_cout | lost_s;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      lost_d  = lost_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = op_s;
               a_d     = a;
               b_d     = b;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               lost_d  = 1'b0;
               state_d = DONE;
               case (op_s)
                  ADD, SUB: begin
                     res_d   = as_sum;
                     carry_d = as_cout;
                     ovf_d   = as_ovf;
                  end
                  AND: res_d = a & b;
                  OR:  res_d = a | b;
                  XOR: res_d = a ^ b;
                  SHL, SHR: begin
                     if (n == '0) begin
                        res_d = a;
                     end else begin
                        res_d   = step_res;
                        carry_d = step_c;
                        if (n != ONE_C) begin
                           cnt_d   = n - ONE_C;
                           state_d = BUSY;
                        end
                     end
                  end
                  MUL: begin
                     res_d   = step_res;
                     carry_d = step_c;
                     a_d     = step_a;
                     b_d     = step_b;
                     lost_d  = step_lost;
                     cnt_d   = W_C - ONE_C;
                     state_d = BUSY;
                  end
                  default: ;
               endcase
            end
         end
         BUSY: begin
            res_d   = step_res;
            carry_d = step_c;
            if (op_q == MUL) begin
               a_d    = step_a;
               b_d    = step_b;
               lost_d = step_lost;
            end
            if (cnt_q == ONE_C) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - ONE_C;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= ADD;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         lost_q  <= lost_d;
      end
   end

   // Outputs are gated by DONE so intermediate iteration values never show.
   assign in_ready   = idle;
   assign out_valid  = done;
   assign busy       = (state_q == BUSY);
   assign result     = done ? res_q : '0;
   assign flag_zero  = done && (res_q == '0);
   assign flag_carry = done && carry_q;
   assign flag_ovf   = done && ovf_q;
   assign flag_neg   = done && res_q[WIDTH-1];

endmodule
